// File: rtl/sram_controller.sv
// Runs one 32-bit load/store as two 16-bit accesses on an async SRAM; latency 3+WAIT_CYCLES cycles per request.
// Backpressure: ready is low from request until the DONE cycle; request inputs must stay stable meanwhile.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_drive,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;

  state_t      state;
  logic        op;
  logic [3:0]  cnt;
  logic [15:0] lo_reg;
  logic [15:0] hi_reg;
  logic [16:0] word;

  // Byte offset from the SRAM base, divided down to a 32-bit word index; wraps silently.
  assign word  = 17'((address - BASE_ADDR) >> 2);
  assign ready = (state == IDLE && !(rd_en | wr_en)) || state == DONE;

  // Bus outputs are registered one state ahead so they are stable for the whole access cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op            <= 1'b0;
      cnt           <= 4'd0;
      lo_reg        <= 16'd0;
      hi_reg        <= 16'd0;
      read_data     <= 32'd0;
      sram_addr     <= 18'd0;
      sram_dq_out   <= 16'd0;
      sram_dq_drive <= 1'b0;
      sram_we_n     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en | wr_en) begin
            op            <= wr_en;
            sram_addr     <= {word, 1'b0};
            sram_dq_out   <= write_data[15:0];
            sram_dq_drive <= wr_en;
            sram_we_n     <= ~wr_en;
            state         <= LOW;
          end
        end
        LOW: begin
          if (!op) lo_reg <= sram_dq_in;
          sram_addr   <= {word, 1'b1};
          sram_dq_out <= write_data[31:16];
          state       <= HIGH;
        end
        HIGH: begin
          if (!op) begin
            hi_reg <= sram_dq_in;
            if (WAIT_CYCLES == 0) read_data <= {sram_dq_in, lo_reg};
          end
          sram_dq_drive <= 1'b0;
          sram_we_n     <= 1'b1;
          cnt           <= 4'd0;
          state         <= (WAIT_CYCLES == 0) ? DONE : WAIT;
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(WAIT_CYCLES - 1)) begin
            if (!op) read_data <= {hi_reg, lo_reg};
            state <= DONE;
          end
        end
        DONE: begin
          cnt   <= 4'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: two instances (WAIT_CYCLES 2 and 0), each with a behavioural async SRAM.
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: default WAIT_CYCLES = 2
  logic        rd_en0, wr_en0, ready0, drive0, we_n0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [17:0] sram_addr0;
  logic [15:0] dq_out0, dq_in0;
  logic [15:0] mem0 [0:1023];

  // Instance 1: WAIT_CYCLES = 0
  logic        rd_en1, wr_en1, ready1, drive1, we_n1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [17:0] sram_addr1;
  logic [15:0] dq_out1, dq_in1;
  logic [15:0] mem1 [0:1023];

  sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) u_dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en0), .wr_en(wr_en0), .address(addr0),
    .write_data(wdata0), .read_data(rdata0), .ready(ready0), .sram_addr(sram_addr0),
    .sram_dq_out(dq_out0), .sram_dq_drive(drive0), .sram_dq_in(dq_in0), .sram_we_n(we_n0));

  sram_controller #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) u_dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1), .address(addr1),
    .write_data(wdata1), .read_data(rdata1), .ready(ready1), .sram_addr(sram_addr1),
    .sram_dq_out(dq_out1), .sram_dq_drive(drive1), .sram_dq_in(dq_in1), .sram_we_n(we_n1));

  // Async SRAM models: combinational read, write committed while we_n is low at the clock edge.
  assign dq_in0 = mem0[sram_addr0[9:0]];
  assign dq_in1 = mem1[sram_addr1[9:0]];
  always @(posedge clk) begin
    if (!we_n0 && drive0) mem0[sram_addr0[9:0]] <= dq_out0;
    if (!we_n1 && drive1) mem1[sram_addr1[9:0]] <= dq_out1;
  end

  int compared = 0;
  int mismatched = 0;

  int          n_cyc, we_lo, dr_hi;
  logic [17:0] a_lo, a_hi;
  logic [31:0] rd_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request at posedge+1 and follows it to the DONE cycle, recording bus activity.
  task automatic do_req(input bit sel, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    logic rdy, wen, drv;
    logic [17:0] sa;
    if (sel) begin rd_en1 = r; wr_en1 = w; addr1 = a; wdata1 = d; end
    else     begin rd_en0 = r; wr_en0 = w; addr0 = a; wdata0 = d; end
    n_cyc = 0; we_lo = 0; dr_hi = 0; a_lo = 'x; a_hi = 'x;
    #1;
    forever begin
      rdy = sel ? ready1 : ready0;
      wen = sel ? we_n1 : we_n0;
      drv = sel ? drive1 : drive0;
      sa  = sel ? sram_addr1 : sram_addr0;
      if (rdy || n_cyc >= 50) break;
      if (n_cyc == 1) a_lo = sa;
      if (n_cyc == 2) a_hi = sa;
      if (!wen) we_lo++;
      if (drv) dr_hi++;
      n_cyc++;
      @(posedge clk); #1;
    end
    if (n_cyc >= 50) chk("ready_timeout", 32'(n_cyc), 32'd0);
    rd_done = sel ? rdata1 : rdata0;
    if (sel) begin rd_en1 = 1'b0; wr_en1 = 1'b0; end
    else     begin rd_en0 = 1'b0; wr_en0 = 1'b0; end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mem0[i] = 16'h0; mem1[i] = 16'h0; end
    rst = 1'b1;
    rd_en0 = 0; wr_en0 = 0; addr0 = 0; wdata0 = 0;
    rd_en1 = 0; wr_en1 = 0; addr1 = 0; wdata1 = 0;
    #12;
    chk("rst_ready",     32'(ready0), 32'd1);
    chk("rst_we_n",      32'(we_n0),  32'd1);
    chk("rst_drive",     32'(drive0), 32'd0);
    chk("rst_read_data", rdata0,      32'd0);
    chk("rst_sram_addr", 32'(sram_addr0), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_req(0, 0, 1, 32'd1024, 32'hDEADBEEF);
    chk("wr1_ready_low", 32'(n_cyc), 32'd5);
    chk("wr1_we_low",    32'(we_lo), 32'd2);
    chk("wr1_drive",     32'(dr_hi), 32'd2);
    chk("wr1_addr_lo",   32'(a_lo),  32'd0);
    chk("wr1_addr_hi",   32'(a_hi),  32'd1);
    chk("wr1_mem0",      32'(mem0[0]), 32'h0000BEEF);
    chk("wr1_mem1",      32'(mem0[1]), 32'h0000DEAD);
    chk("wr1_rdata",     rdata0,     32'd0);

    do_req(0, 1, 0, 32'd1024, 32'h0);
    chk("rd1_ready_low", 32'(n_cyc), 32'd5);
    chk("rd1_we_low",    32'(we_lo), 32'd0);
    chk("rd1_done_data", rd_done,    32'hDEADBEEF);
    chk("rd1_idle_hold", rdata0,     32'hDEADBEEF);

    do_req(0, 0, 1, 32'd1031, 32'h12345678);
    chk("wr2_addr_lo",   32'(a_lo), 32'd2);
    chk("wr2_addr_hi",   32'(a_hi), 32'd3);
    do_req(0, 1, 0, 32'd1028, 32'h0);
    chk("rd2_done_data", rd_done,   32'h12345678);

    do_req(0, 1, 1, 32'd1040, 32'hCAFEF00D);
    chk("both_we_low",   32'(we_lo),   32'd2);
    chk("both_mem8",     32'(mem0[8]), 32'h0000F00D);
    chk("both_mem9",     32'(mem0[9]), 32'h0000CAFE);
    chk("both_rdata",    rdata0,       32'h12345678);

    // Abort a write during its high half.
    wr_en0 = 1'b1; addr0 = 32'd1024; wdata0 = 32'hAAAA5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_in_high_we", 32'(we_n0), 32'd0);
    chk("abort_in_high_addr", 32'(sram_addr0), 32'd1);
    rst = 1'b1; wr_en0 = 1'b0;
    #1;
    chk("abort_we_n",  32'(we_n0),  32'd1);
    chk("abort_rdata", rdata0,      32'd0);
    chk("abort_ready", 32'(ready0), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_mem0", 32'(mem0[0]), 32'h00005555);
    chk("abort_mem1", 32'(mem0[1]), 32'h0000DEAD);
    @(posedge clk); #1;
    do_req(0, 1, 0, 32'd1024, 32'h0);
    chk("abort_rd_data", rd_done, 32'hDEAD5555);

    do_req(1, 0, 1, 32'd1024, 32'h11223344);
    chk("w0_wr_ready_low", 32'(n_cyc), 32'd3);
    chk("w0_wr_we_low",    32'(we_lo), 32'd2);
    do_req(1, 1, 0, 32'd1024, 32'h0);
    chk("w0_rd_ready_low", 32'(n_cyc), 32'd3);
    chk("w0_rd_data",      rd_done,    32'h11223344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
